// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the WISC memory stage.
//   state_t      : request FSM states (IDLE / ACCESS / HALTED)
//   TIMEOUT_DEF  : default ACCESS cycle budget before an abort
//   cnt_width()  : wait-counter width for a given budget
package memory_stage_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam int TIMEOUT_DEF = 64;

   // A budget of 1 still needs a 1-bit counter.
   function automatic int cnt_width(input int t);
      return (t > 1) ? $clog2(t) : 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/memory_stage_if.sv
// Request/done data-memory bus between the memory stage and data memory.
//   master : memory stage (drives the request, receives read data / done)
//   slave  : data memory
interface memory_stage_if;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_done;

   modport master (
      output mem_en, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_done
   );

   modport slave (
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_done
   );
endinterface

// File: rtl/memory_stage_mem_req_fsm.sv
// Request FSM of the memory stage: state register, wait counter, latched
// request (address, write data, direction, PC and control bits) and the
// stall / mem_en generation.
//   i_valid..i_pcs : EX/MEM contents, i_illegal from the legality check
//   i_mem_done     : memory completion
//   o_mem_*        : request bus values
//   o_pcs/o_memtoreg/o_dump : control captured with the request
//   o_pass         : non-memory instruction retiring from IDLE this cycle
//   o_done         : memory access completing this cycle
//   o_timeout      : access aborted this cycle
module mem_req_fsm
   import memory_stage_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic        i_memtoreg,
   input  logic        i_dump,
   input  logic        i_illegal,
   input  logic [15:0] i_aluo,
   input  logic [15:0] i_rd2,
   input  logic [15:0] i_pcs,
   input  logic        i_mem_done,
   output state_t      o_state,
   output logic        o_mem_en,
   output logic        o_mem_wr,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_mem_wdata,
   output logic [15:0] o_pcs,
   output logic        o_memtoreg,
   output logic        o_dump,
   output logic        o_stall,
   output logic        o_pass,
   output logic        o_done,
   output logic        o_timeout
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_mem_wr;
   logic [15:0]        r_mem_addr;
   logic [15:0]        r_mem_wdata;
   logic [15:0]        r_pcs;
   logic               r_memtoreg;
   logic               r_dump;
   logic               w_memop;
   logic               w_req;

   assign w_memop   = i_mem_read | i_mem_write;
   assign w_req     = (r_state == IDLE) & i_valid & w_memop & ~i_illegal;
   assign o_pass    = (r_state == IDLE) & i_valid & ~w_memop;
   assign o_done    = (r_state == ACCESS) & i_mem_done;
   assign o_timeout = (r_state == ACCESS) & ~i_mem_done
                      & (r_cnt == CNT_W'(TIMEOUT - 1));

   // NOTE: every comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_req)                 w_next = ACCESS;
            else if (o_pass && i_dump) w_next = HALTED;
         end
         ACCESS: begin
            if (o_done)         w_next = r_dump ? HALTED : IDLE;
            else if (o_timeout) w_next = IDLE;
         end
         HALTED:  w_next = HALTED;
         default: w_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_mem_wr    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_pcs       <= '0;
         r_memtoreg  <= 1'b0;
         r_dump      <= 1'b0;
      end else begin
         if (w_req) begin
            r_mem_wr    <= i_mem_write;
            r_mem_addr  <= i_aluo;
            r_mem_wdata <= i_rd2;
            r_pcs       <= i_pcs;
            r_memtoreg  <= i_memtoreg;
            r_dump      <= i_dump;
         end
         if ((r_state == ACCESS) && !o_done && !o_timeout) r_cnt <= r_cnt + 1'b1;
         else                                              r_cnt <= '0;
      end
   end

   // mem_en is a decode of the state flop, so it falls with reset at once.
   assign o_mem_en    = (r_state == ACCESS);
   assign o_mem_wr    = r_mem_wr;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_pcs       = r_pcs;
   assign o_memtoreg  = r_memtoreg;
   assign o_dump      = r_dump;
   assign o_state     = r_state;

   // Gated by reset so every output reads 0 while reset is held.
   assign o_stall = rst & (w_req
                           | ((r_state == ACCESS) & ~i_mem_done)
                           | (r_state == HALTED));

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the 16-bit WISC pipeline. Takes EX/MEM, performs at most
// one load/store over the request/done bus, stalls upstream while it waits
// and produces MEM/WB. Sticky err (illegal access / timeout) and halt (Dump).
//   clk, rst       : clock, async active-low reset
//   *_EXMEM        : EX/MEM pipeline register inputs
//   mem            : data-memory bus (master side)
//   stall          : hold PC, IF/ID, ID/EX and EX/MEM
//   *_MEMWB        : MEM/WB pipeline register outputs
//   halt, err      : sticky status
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_EXMEM,
   input  logic [15:0]           ALUO_EXMEM,
   input  logic [15:0]           Rd2_EXMEM,
   input  logic [15:0]           PCS_EXMEM,
   input  logic                  MemRead_EXMEM,
   input  logic                  MemWrite_EXMEM,
   input  logic                  MemtoReg_EXMEM,
   input  logic                  Dump_EXMEM,
   memory_stage_if.master        mem,
   output logic                  stall,
   output logic                  valid_MEMWB,
   output logic [15:0]           WBdata_MEMWB,
   output logic [15:0]           PCS_MEMWB,
   output logic                  halt,
   output logic                  err
);

   state_t      w_state;
   logic        w_illegal;
   logic        w_pass;
   logic        w_done;
   logic        w_timeout;
   logic        w_memtoreg;
   logic        w_dump;
   logic [15:0] w_req_pcs;
   logic [15:0] w_wb_mux;

   logic        r_valid;
   logic [15:0] r_wbdata;
   logic [15:0] r_pcs;
   logic        r_halt;
   logic        r_err;

   // Both directions at once, or a memory op on an odd address.
   assign w_illegal = valid_EXMEM
                      & ((MemRead_EXMEM & MemWrite_EXMEM)
                         | ((MemRead_EXMEM | MemWrite_EXMEM) & ALUO_EXMEM[0]));

   mem_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (valid_EXMEM),
      .i_mem_read  (MemRead_EXMEM),
      .i_mem_write (MemWrite_EXMEM),
      .i_memtoreg  (MemtoReg_EXMEM),
      .i_dump      (Dump_EXMEM),
      .i_illegal   (w_illegal),
      .i_aluo      (ALUO_EXMEM),
      .i_rd2       (Rd2_EXMEM),
      .i_pcs       (PCS_EXMEM),
      .i_mem_done  (mem.mem_done),
      .o_state     (w_state),
      .o_mem_en    (mem.mem_en),
      .o_mem_wr    (mem.mem_wr),
      .o_mem_addr  (mem.mem_addr),
      .o_mem_wdata (mem.mem_wdata),
      .o_pcs       (w_req_pcs),
      .o_memtoreg  (w_memtoreg),
      .o_dump      (w_dump),
      .o_stall     (stall),
      .o_pass      (w_pass),
      .o_done      (w_done),
      .o_timeout   (w_timeout)
   );

   // The latched address doubles as the ALU result for a retiring store.
   assign w_wb_mux = w_memtoreg ? mem.mem_rdata : mem.mem_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid  <= 1'b0;
         r_wbdata <= '0;
         r_pcs    <= '0;
         r_halt   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         if (w_pass) begin
            r_valid  <= 1'b1;
            r_wbdata <= ALUO_EXMEM;
            r_pcs    <= PCS_EXMEM;
         end else if (w_done) begin
            r_valid  <= 1'b1;
            r_wbdata <= w_wb_mux;
            r_pcs    <= w_req_pcs;
         end else begin
            r_valid  <= 1'b0;
         end
         if ((w_illegal && (w_state == IDLE)) || w_timeout) r_err <= 1'b1;
         if ((w_pass && Dump_EXMEM) || (w_done && w_dump))  r_halt <= 1'b1;
      end
   end

   assign valid_MEMWB  = r_valid;
   assign WBdata_MEMWB = r_wbdata;
   assign PCS_MEMWB    = r_pcs;
   assign halt         = r_halt;
   assign err          = r_err;

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (TIMEOUT = 8).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge (registered) or 1 ns after an input change (combinational).
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_EXMEM;
   logic [15:0] ALUO_EXMEM;
   logic [15:0] Rd2_EXMEM;
   logic [15:0] PCS_EXMEM;
   logic        MemRead_EXMEM;
   logic        MemWrite_EXMEM;
   logic        MemtoReg_EXMEM;
   logic        Dump_EXMEM;
   logic        stall;
   logic        valid_MEMWB;
   logic [15:0] WBdata_MEMWB;
   logic [15:0] PCS_MEMWB;
   logic        halt;
   logic        err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   memory_stage_if mem_bus ();

   memory_stage #(.TIMEOUT(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .valid_EXMEM    (valid_EXMEM),
      .ALUO_EXMEM     (ALUO_EXMEM),
      .Rd2_EXMEM      (Rd2_EXMEM),
      .PCS_EXMEM      (PCS_EXMEM),
      .MemRead_EXMEM  (MemRead_EXMEM),
      .MemWrite_EXMEM (MemWrite_EXMEM),
      .MemtoReg_EXMEM (MemtoReg_EXMEM),
      .Dump_EXMEM     (Dump_EXMEM),
      .mem            (mem_bus),
      .stall          (stall),
      .valid_MEMWB    (valid_MEMWB),
      .WBdata_MEMWB   (WBdata_MEMWB),
      .PCS_MEMWB      (PCS_MEMWB),
      .halt           (halt),
      .err            (err)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] rd2,
                        input logic [15:0] pcs, input logic mr, input logic mw,
                        input logic m2r, input logic dmp);
      valid_EXMEM    = v;
      ALUO_EXMEM     = alu;
      Rd2_EXMEM      = rd2;
      PCS_EXMEM      = pcs;
      MemRead_EXMEM  = mr;
      MemWrite_EXMEM = mw;
      MemtoReg_EXMEM = m2r;
      Dump_EXMEM     = dmp;
   endtask

   task automatic bubble();
      drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, valid_MEMWB,       16'h0);
      check({tag, "_wb"},    WBdata_MEMWB,      16'h0);
      check({tag, "_pcs"},   PCS_MEMWB,         16'h0);
      check({tag, "_halt"},  halt,              16'h0);
      check({tag, "_err"},   err,               16'h0);
      check({tag, "_en"},    mem_bus.mem_en,    16'h0);
      check({tag, "_wr"},    mem_bus.mem_wr,    16'h0);
      check({tag, "_addr"},  mem_bus.mem_addr,  16'h0);
      check({tag, "_wdata"}, mem_bus.mem_wdata, 16'h0);
      check({tag, "_stall"}, stall,             16'h0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      bubble();
      mem_bus.mem_done  = 1'b0;
      mem_bus.mem_rdata = 16'h0;
      repeat (2) @(negedge clk);
      check_zero(tag);
      rst = 1'b1;
   endtask

   // One load/store: request cycle, then n_en ACCESS cycles with done on the last.
   task automatic mem_op(input string tag, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] pcs, input logic is_wr, input logic m2r,
                         input int n_en, input logic [15:0] rdata, input logic [15:0] exp_wb);
      int stalls = 0;
      @(negedge clk);
      drive(1'b1, addr, wdata, pcs, ~is_wr, is_wr, m2r, 1'b0);
      #1;
      check({tag, "_req_en"}, mem_bus.mem_en, 16'h0);
      if (stall) stalls++;
      for (int k = 0; k < n_en; k++) begin
         @(negedge clk);
         mem_bus.mem_done  = (k == n_en - 1);
         mem_bus.mem_rdata = (k == n_en - 1) ? rdata : 16'h0;
         #1;
         check({tag, "_en"},   mem_bus.mem_en,   16'h1);
         check({tag, "_addr"}, mem_bus.mem_addr, addr);
         check({tag, "_wr"},   mem_bus.mem_wr,   {15'h0, is_wr});
         if (is_wr) check({tag, "_wdata"}, mem_bus.mem_wdata, wdata);
         if (stall) stalls++;
      end
      @(negedge clk);
      mem_bus.mem_done  = 1'b0;
      mem_bus.mem_rdata = 16'h0;
      bubble();
      check({tag, "_valid"}, valid_MEMWB,  16'h1);
      check({tag, "_wb"},    WBdata_MEMWB, exp_wb);
      check({tag, "_pcs"},   PCS_MEMWB,    pcs);
      check({tag, "_en_off"}, mem_bus.mem_en, 16'h0);
      check({tag, "_stalls"}, 16'(stalls), 16'(n_en));
      #1 check({tag, "_stall_after"}, stall, 16'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bubble();
      mem_bus.mem_done  = 1'b0;
      mem_bus.mem_rdata = 16'h0;
      do_reset("reset");

      // ALU op passes straight through, never stalls.
      @(negedge clk);
      drive(1'b1, 16'h1234, 16'h0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("alu_stall", stall, 16'h0);
      @(negedge clk);
      bubble();
      check("alu_valid", valid_MEMWB,  16'h1);
      check("alu_wb",    WBdata_MEMWB, 16'h1234);
      check("alu_pcs",   PCS_MEMWB,    16'h0002);
      #1 check("alu_stall2", stall, 16'h0);
      @(negedge clk);
      check("bubble_valid", valid_MEMWB, 16'h0);

      // Load with 3 mem_en cycles, store with same-cycle done.
      mem_op("load",  16'h0040, 16'h0000, 16'h0004, 1'b0, 1'b1, 3, 16'hBEEF, 16'hBEEF);
      mem_op("store", 16'h0010, 16'hA5A5, 16'h0006, 1'b1, 1'b0, 1, 16'h0000, 16'h0010);

      // Reset in the middle of an access.
      @(negedge clk);
      drive(1'b1, 16'h0080, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1 check("rstmid_en", mem_bus.mem_en, 16'h1);
      #2 rst = 1'b0;
      #1 check_zero("rstmid");
      @(negedge clk);
      bubble();
      @(negedge clk);
      rst = 1'b1;

      // Timeout: done never comes, abort after 8 ACCESS cycles.
      @(negedge clk);
      drive(1'b1, 16'h0020, 16'h0, 16'h000A, 1'b1, 1'b0, 1'b1, 1'b0);
      #1 check("to_req_stall", stall, 16'h1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         #1;
         check("to_en",    mem_bus.mem_en, 16'h1);
         check("to_err0",  err,            16'h0);
         check("to_stall", stall,          16'h1);
      end
      @(negedge clk);
      drive(1'b1, 16'h5555, 16'h0, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0);
      check("to_err",   err,            16'h1);
      check("to_en_off", mem_bus.mem_en, 16'h0);
      check("to_valid", valid_MEMWB,    16'h0);
      #1 check("to_idle_stall", stall, 16'h0);
      @(negedge clk);
      bubble();
      check("to_next_valid", valid_MEMWB,  16'h1);
      check("to_next_wb",    WBdata_MEMWB, 16'h5555);

      // Illegal accesses: odd address, then read+write together.
      do_reset("reset2");
      @(negedge clk);
      drive(1'b1, 16'h0011, 16'h0, 16'h0010, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      check("odd_stall", stall,          16'h0);
      check("odd_en",    mem_bus.mem_en, 16'h0);
      @(negedge clk);
      drive(1'b1, 16'h0020, 16'h0, 16'h0012, 1'b1, 1'b1, 1'b0, 1'b0);
      check("odd_err",   err,            16'h1);
      check("odd_valid", valid_MEMWB,    16'h0);
      check("odd_en2",   mem_bus.mem_en, 16'h0);
      #1 check("rw_stall", stall, 16'h0);
      @(negedge clk);
      bubble();
      check("rw_err",   err,            16'h1);
      check("rw_valid", valid_MEMWB,    16'h0);
      check("rw_en",    mem_bus.mem_en, 16'h0);
      @(negedge clk);
      check("rw_err_sticky", err, 16'h1);

      // Dump without a memory op halts the stage.
      do_reset("reset3");
      @(negedge clk);
      drive(1'b1, 16'h0077, 16'h0, 16'h000E, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 check("dump_stall", stall, 16'h0);
      @(negedge clk);
      drive(1'b1, 16'h9999, 16'h0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
      check("dump_valid", valid_MEMWB,  16'h1);
      check("dump_wb",    WBdata_MEMWB, 16'h0077);
      check("dump_pcs",   PCS_MEMWB,    16'h000E);
      check("dump_halt",  halt,         16'h1);
      #1 check("halt_stall", stall, 16'h1);
      @(negedge clk);
      drive(1'b1, 16'h0040, 16'h0, 16'h0012, 1'b1, 1'b0, 1'b1, 1'b0);
      check("halt_valid", valid_MEMWB, 16'h0);
      check("halt_halt",  halt,        16'h1);
      #1;
      check("halt_stall2", stall,          16'h1);
      check("halt_en",     mem_bus.mem_en, 16'h0);
      @(negedge clk);
      bubble();
      check("halt_valid2", valid_MEMWB,    16'h0);
      check("halt_en2",    mem_bus.mem_en, 16'h0);
      check("halt_halt2",  halt,           16'h1);
      #1 check("halt_stall3", stall, 16'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the five-stage pipelined 16-bit WISC core. Consumes the EX/MEM pipeline registers produced by the execute stage and performs at most one load or store per instruction against a multi-cycle data memory using a request/done handshake. Stalls the upstream pipeline while an access is outstanding and produces the MEM/WB pipeline registers. Also raises sticky `err` on illegal accesses and sticky `halt` on Dump.

## Interface
- `TIMEOUT`, 64: max cycles in ACCESS without `mem_done` before an error abort.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `valid_EXMEM` in 1: EX/MEM holds a real instruction (0 = bubble).
- `ALUO_EXMEM` in 16: ALU result; memory address for loads and stores.
- `Rd2_EXMEM` in 16: store data.
- `PCS_EXMEM` in 16: next PC, passed through.
- `MemRead_EXMEM`, `MemWrite_EXMEM`, `MemtoReg_EXMEM`, `Dump_EXMEM` in 1 each: control bits.
- `mem_en` out 1: memory request, held until done.
- `mem_wr` out 1: 1 = write, 0 = read.
- `mem_addr` out 16: word-aligned address.
- `mem_wdata` out 16: write data.
- `mem_rdata` in 16: read data, valid when `mem_done` = 1.
- `mem_done` in 1: access complete; may assert in the first `mem_en` cycle.
- `stall` out 1: hold PC, IF/ID, ID/EX and EX/MEM.
- `valid_MEMWB` out 1: MEM/WB holds a real instruction.
- `WBdata_MEMWB` out 16: writeback value.
- `PCS_MEMWB` out 16: next PC.
- `halt` out 1: sticky; Dump instruction has retired.
- `err` out 1: sticky; illegal access or timeout.

## Operation
- FSM states: IDLE, ACCESS, HALTED. Reset state is IDLE.
- Reset values: all outputs 0. Wait counter is 0.
- IDLE, bubble (`valid_EXMEM` = 0):
  - `valid_MEMWB` <= 0.
  - `stall` = 0.
- IDLE, valid instruction with no memory op:
  - `WBdata_MEMWB` <= `ALUO_EXMEM`; `PCS_MEMWB` <= `PCS_EXMEM`; `valid_MEMWB` <= 1.
  - `stall` = 0.
- IDLE, valid instruction with exactly one of MemRead/MemWrite and `ALUO_EXMEM[0]` = 0:
  - Register `mem_addr`, `mem_wdata`, `mem_wr` and the control bits.
  - Next state ACCESS with `mem_en` = 1.
  - `stall` = 1 combinationally in this cycle.
  - `valid_MEMWB` <= 0.
- Illegal access: MemRead and MemWrite both set, or odd address.
  - `err` <= 1.
  - No request is issued; the instruction becomes a bubble (`valid_MEMWB` <= 0).
  - `stall` = 0.
- ACCESS:
  - `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata` stay stable.
  - `stall` = ~`mem_done`.
  - The counter increments every cycle.
  - On `mem_done`:
    - `WBdata_MEMWB` <= (`MemtoReg` ? `mem_rdata` : ALUO).
    - `PCS_MEMWB` latched; `valid_MEMWB` <= 1.
    - `mem_en` <= 0; counter cleared.
    - Next state: HALTED if Dump, else IDLE.
  - Timeout: counter reaches `TIMEOUT`-1 without `mem_done`.
    - `err` <= 1, `mem_en` <= 0, `valid_MEMWB` <= 0, next state IDLE.
- Dump without a memory op: retires from IDLE straight to HALTED.
- HALTED:
  - `halt` = 1 and `stall` = 1.
  - `valid_MEMWB` <= 0 after the Dump retirement cycle.
  - The only exit is reset.
- `err` and `halt` clear only on reset.
- Reset mid-ACCESS:
  - `mem_en` drops asynchronously; the access is abandoned.
  - Memory must tolerate an abandoned access.

## Timing
- Non-memory instruction: 1 cycle (EX/MEM → MEM/WB on the next edge).
- Memory op, minimum: 2 cycles (IDLE request cycle, then ACCESS with same-cycle `mem_done`).
- Memory op, general: 1 + N cycles, where N is the number of cycles `mem_en` is high.
- `stall` is high exactly in the request cycle and in ACCESS cycles before `mem_done`.
- EX/MEM advances on the edge where `mem_done` = 1.
- Back-to-back memory ops: the second request is seen in IDLE on the cycle after done, so `mem_en` is low for at least 1 cycle between requests.
- `mem_done` is ignored outside ACCESS.

## Structure
- Package `memory_stage_pkg` holds:
  - the state enum (IDLE/ACCESS/HALTED);
  - the `TIMEOUT` default;
  - the counter width, $clog2(`TIMEOUT`).
- One sub-module, `mem_req_fsm`: the state register, wait counter, request registers and `stall`/`mem_en` generation.
- The top level holds:
  - the MEM/WB registers and writeback mux;
  - the sticky `err`/`halt` flops;
  - the legality check.

## Test plan
- ALU op, ALUO = 16'h1234, no MemRead/MemWrite → next cycle WBdata_MEMWB = 16'h1234, valid_MEMWB = 1, `stall` never high.
- Load, addr 16'h0040, memory returns 16'hBEEF after 3 `mem_en` cycles, MemtoReg = 1 → `stall` high 3 cycles, WBdata_MEMWB = 16'hBEEF, mem_addr stable at 16'h0040.
- Store, addr 16'h0010, data 16'hA5A5, same-cycle done → mem_wr = 1, mem_wdata = 16'hA5A5, `stall` high exactly 1 cycle, WBdata_MEMWB = 16'h0010.
- Load at odd addr 16'h0011, then MemRead+MemWrite both set → `err` = 1 after the first, no `mem_en` either time, both retire as bubbles, `err` still 1 afterwards.
- `mem_done` never asserted, `TIMEOUT` = 8 → `err` rises after 8 ACCESS cycles, `mem_en` falls, FSM returns to IDLE.
- Dump retired, then more instructions; separately, rst low mid-ACCESS → `halt` = 1 and `stall` = 1 with no further valid_MEMWB; on rst low, `mem_en` = 0 immediately and all outputs read 0.
